// File: rtl/transistor_sweep_sequencer_pkg.sv
// sweep_pkg: shared states, default widths and vote length for the transistor sweep sequencer.
package sweep_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, STEP, DONE} state_t;
  localparam int CODE_W_DEF = 8;
  localparam int SETTLE_W_DEF = 8;
  localparam int VOTE_LEN = 3;
endpackage

// File: rtl/transistor_sweep_sequencer_cmp_sync_vote.sv
// cmp_sync_vote: 2-flop comparator synchronizer with optional 3-sample majority vote (SWEEP_VOTE_EN).
module cmp_sync_vote
  import sweep_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cmp_in,
  input  logic sample,
  output logic decision,
  output logic decision_valid
);
  logic [1:0] sync;
  logic cmp_s;
  assign cmp_s = sync[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], cmp_in};
`ifdef SWEEP_VOTE_EN
  logic [1:0] cnt;
  logic [1:0] votes;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      votes <= '0;
    end else if (!sample || decision_valid) cnt <= '0;
    else begin
      cnt <= cnt + 2'd1;
      votes <= {votes[0], cmp_s};
    end
  assign decision_valid = sample && cnt == 2'(VOTE_LEN - 1);
  // third vote is the live sample, so the decision lands in the last SAMPLE cycle
  assign decision = (votes[0] & votes[1]) | (cmp_s & (votes[0] | votes[1]));
`else
  assign decision_valid = sample;
  assign decision = cmp_s;
`endif
endmodule

// File: rtl/transistor_sweep_sequencer.sv
// transistor_sweep_sequencer: steps a DAC code over a range and reports the first comparator trip code.
// Optional majority-vote sampling is enabled by defining SWEEP_VOTE_EN.
module transistor_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CODE_W-1:0]   code_lo,
  input  logic [CODE_W-1:0]   code_hi,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                cmp_in,
  output logic [CODE_W-1:0]   dac_code,
  output logic                busy,
  output logic                result_valid,
  output logic [CODE_W-1:0]   result_code,
  output logic                found,
  output logic                range_err,
  input  logic                result_ack
);
  state_t state, state_n;
  logic [CODE_W-1:0] hi_r;
  logic [SETTLE_W-1:0] settle_r, cnt;
  logic decision, decision_valid;
  cmp_sync_vote u_cmp (
    .clk(clk),
    .rst(rst),
    .cmp_in(cmp_in),
    .sample(state == SAMPLE),
    .decision(decision),
    .decision_valid(decision_valid)
  );
  assign busy = state == SETTLE || state == SAMPLE || state == STEP;
  assign result_valid = state == DONE;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else
      case (state)
        IDLE:    if (start) state_n = code_lo > code_hi ? DONE : SETTLE;
        SETTLE:  if (cnt == '0) state_n = SAMPLE;
        SAMPLE:  if (decision_valid) state_n = decision || dac_code == hi_r ? DONE : STEP;
        STEP:    state_n = SETTLE;
        DONE:    if (result_ack) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dac_code <= '0;
      hi_r <= '0;
      settle_r <= '0;
      cnt <= '0;
      result_code <= '0;
      found <= 1'b0;
      range_err <= 1'b0;
    end else if (abort) begin
      result_code <= '0;
      found <= 1'b0;
      range_err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            found <= 1'b0;
            result_code <= '0;
            if (code_lo > code_hi) range_err <= 1'b1;
            else begin
              dac_code <= code_lo;
              hi_r <= code_hi;
              settle_r <= settle_cycles;
              cnt <= settle_cycles;
            end
          end
        SETTLE: if (cnt != '0) cnt <= cnt - SETTLE_W'(1);
        SAMPLE:
          if (decision_valid) begin
            found <= decision;
            if (decision || dac_code == hi_r) result_code <= dac_code;
          end
        STEP: begin
          dac_code <= dac_code + CODE_W'(1);
          cnt <= settle_r;
        end
        DONE: if (result_ack) range_err <= 1'b0;
        default: ;
      endcase
endmodule

// File: tb/tb_transistor_sweep_sequencer.sv
// tb_transistor_sweep_sequencer: directed self-checking bench; define SWEEP_VOTE_EN to cover voting.
module tb_transistor_sweep_sequencer;
`ifdef SWEEP_VOTE_EN
  localparam int SMP = 3;
`else
  localparam int SMP = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, result_ack = 1'b0;
  logic cmp_mode = 1'b0, cmp_force = 1'b0;
  logic [7:0] code_lo = '0, code_hi = '0, settle_cycles = '0, thr = '0;
  logic cmp_in;
  logic [7:0] dac_code, result_code;
  logic busy, result_valid, found, range_err;
  int tests = 0, fails = 0, n = 0;
  logic saw_valid;
  assign cmp_in = cmp_mode ? (dac_code >= thr) : cmp_force;
  transistor_sweep_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .code_lo(code_lo), .code_hi(code_hi), .settle_cycles(settle_cycles),
    .cmp_in(cmp_in), .dac_code(dac_code), .busy(busy),
    .result_valid(result_valid), .result_code(result_code),
    .found(found), .range_err(range_err), .result_ack(result_ack)
  );
  always #5 clk = ~clk;
  function automatic int lat(input int k, input int s);
    return 1 + k * (s + 2 + SMP) + s + 1 + SMP;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] s);
    @(negedge clk);
    code_lo = lo;
    code_hi = hi;
    settle_cycles = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_valid(input int n0, output int nn);
    nn = n0;
    while (!result_valid && nn < 400) begin
      @(posedge clk);
      #1 nn++;
    end
  endtask
  task automatic ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1 result_ack = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_dac", dac_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_code", result_code, 0);
    chk("rst_found", found, 0);
    chk("rst_rerr", range_err, 0);
    @(negedge clk) rst = 1'b0;
    cmp_mode = 1'b1;
    thr = 8'd23;
    go(8'd10, 8'd50, 8'd4);
    chk("trip_busy", busy, 1);
    chk("trip_dac0", dac_code, 10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    code_lo = 8'd0;
    code_hi = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(12, n);
    chk("trip_lat", n, lat(13, 4));
    chk("trip_found", found, 1);
    chk("trip_code", result_code, 23);
    chk("trip_dac", dac_code, 23);
    chk("trip_busy_done", busy, 0);
    go(8'd9, 8'd3, 8'd4);
    chk("done_start_valid", result_valid, 1);
    chk("done_start_rerr", range_err, 0);
    chk("done_start_code", result_code, 23);
    ack();
    chk("ack_valid", result_valid, 0);
    cmp_mode = 1'b0;
    cmp_force = 1'b0;
    go(8'd0, 8'd5, 8'd4);
    wait_valid(1, n);
    chk("notrip_lat", n, lat(5, 4));
    chk("notrip_found", found, 0);
    chk("notrip_code", result_code, 5);
    chk("notrip_dac", dac_code, 5);
    ack();
    go(8'd9, 8'd3, 8'd4);
    chk("rerr_valid", result_valid, 1);
    chk("rerr_flag", range_err, 1);
    chk("rerr_found", found, 0);
    ack();
    chk("rerr_clear", range_err, 0);
    cmp_force = 1'b1;
    go(8'd255, 8'd255, 8'd4);
    wait_valid(1, n);
    chk("top_lat", n, lat(0, 4));
    chk("top_code", result_code, 255);
    chk("top_found", found, 1);
    chk("top_dac", dac_code, 255);
    ack();
    cmp_force = 1'b0;
    go(8'd0, 8'd10, 8'd4);
    repeat (2 * (4 + 2 + SMP) + 2) @(posedge clk);
    #1 chk("abort_pre_dac", dac_code, 2);
    chk("abort_pre_busy", busy, 1);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dac_hold", dac_code, 2);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 saw_valid |= result_valid;
    end
    chk("abort_no_valid", saw_valid, 0);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abort_start_ign", busy, 0);
    cmp_force = 1'b1;
    go(8'd3, 8'd8, 8'd2);
    wait_valid(1, n);
    chk("fresh_lat", n, lat(0, 2));
    chk("fresh_code", result_code, 3);
    chk("fresh_found", found, 1);
    ack();
`ifdef SWEEP_VOTE_EN
    cmp_force = 1'b0;
    go(8'd0, 8'd0, 8'd4);
    repeat (3) @(posedge clk);
    #1 cmp_force = 1'b1;
    @(posedge clk);
    #1 cmp_force = 1'b0;
    wait_valid(5, n);
    chk("vote1_lat", n, lat(0, 4));
    chk("vote1_found", found, 0);
    ack();
    go(8'd0, 8'd0, 8'd4);
    repeat (3) @(posedge clk);
    #1 cmp_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmp_force = 1'b0;
    wait_valid(6, n);
    chk("vote2_found", found, 1);
    ack();
`endif
    cmp_force = 1'b0;
    go(8'd7, 8'd20, 8'd4);
    chk("arst_pre_dac", dac_code, 7);
    #3 rst = 1'b1;
    #1;
    chk("arst_dac", dac_code, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_code", result_code, 0);
    chk("arst_found", found, 0);
    chk("arst_rerr", range_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
